// File: rtl/data_mem_responder_if.sv
// Processor data-port bundle: valid/ready request channel plus single-cycle response.
// master = processor side, slave = memory responder side.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data memory answering lw/sw with WAIT_CYCLES wait states and a one-cycle response.
// Optional macro DMEM_ALIGN_CHECK_EN flags misaligned accesses via resp_err and suppresses them.
module data_mem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  data_mem_responder_if.slave bus
);
  localparam int unsigned IDX_W     = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state, stateNext;
  logic [3:0]         waitCnt;
  logic               outOfReset;
  logic               holdWrite, holdMis;
  logic [IDX_W-1:0]   holdIdx;
  logic [31:0]        holdWdata;
  logic               accept, enterResp;
  logic               accWrite, accMis;
  logic [IDX_W-1:0]   accIdx;
  logic [31:0]        accWdata;
  logic               reqMis;
  logic [31:0]        respRdata;
  logic               respErr;
  logic [31:0]        mem [DEPTH];
  logic               unusedAddrBits;

`ifdef DMEM_ALIGN_CHECK_EN
  assign reqMis = |bus.req_addr[1:0];
`else
  assign reqMis = 1'b0;
`endif

  assign unusedAddrBits = ^{bus.req_addr[31:2+IDX_W], bus.req_addr[1:0]};

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    case (state)
      IDLE: if (bus.req_valid && outOfReset) begin
        accept    = 1'b1;
        stateNext = (WAIT_CYCLES == 0) ? RESP : WAIT;
      end
      WAIT:    if (waitCnt == 4'd1) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    enterResp = (stateNext == RESP) && (state != RESP);

    // With zero wait states the commit edge is also the accept edge, so use the live request.
    if (state == IDLE) begin
      accWrite = bus.req_write;
      accMis   = reqMis;
      accIdx   = bus.req_addr[2 +: IDX_W];
      accWdata = bus.req_wdata;
    end else begin
      accWrite = holdWrite;
      accMis   = holdMis;
      accIdx   = holdIdx;
      accWdata = holdWdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      outOfReset <= 1'b0;
      waitCnt    <= '0;
      holdWrite  <= 1'b0;
      holdMis    <= 1'b0;
      holdIdx    <= '0;
      holdWdata  <= '0;
      respRdata  <= '0;
      respErr    <= 1'b0;
    end else begin
      state      <= stateNext;
      outOfReset <= 1'b1;
      if (accept) begin
        holdWrite <= bus.req_write;
        holdMis   <= reqMis;
        holdIdx   <= bus.req_addr[2 +: IDX_W];
        holdWdata <= bus.req_wdata;
        waitCnt   <= WAIT_LOAD;
      end else if (state == WAIT) begin
        waitCnt <= waitCnt - 4'd1;
      end
      respRdata <= '0;
      respErr   <= 1'b0;
      if (enterResp) begin
        respErr <= accMis;
        if (!accWrite && !accMis) respRdata <= mem[accIdx];
      end
    end
  end

  // Storage is deliberately never reset.
  always_ff @(posedge clk) begin
    if (enterResp && accWrite && !accMis) mem[accIdx] <= accWdata;
  end

  assign bus.req_ready  = (state == IDLE) && outOfReset;
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = respRdata;
  assign bus.resp_err   = respErr;
endmodule
